aes_stream_driver: RTL and testbench

Streaming front-end for the pipelined AES core. It accepts a byte stream through a valid/ready handshake and packs it into 128-bit blocks, zero-padding the final partial block. Each block is issued to the core with a per-message key and a per-message encrypt/decrypt mode. Core results go into an output buffer and are returned as a byte stream with a last marker. A credit scheme keeps the non-stallable core from ever overflowing the buffer, and a drain counter discards core results that were in flight across a reset.

---
 rtl/aes_stream_driver.sv | 210 +++++++++++++++++++++
 tb/tb_aes_stream_driver.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_driver.sv
// aes_stream_driver: byte-stream front-end for a pipelined, non-stallable AES
// core. Packs input bytes into zero-padded 128-bit blocks, issues them with a
// per-message key/mode, buffers core results under a credit scheme and
// serialises them back out as bytes with a last marker.
module aes_stream_driver #(
   parameter int unsigned OUT_DEPTH    = 4,
   parameter int unsigned CORE_LATENCY = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key,
   input  logic         decrypt,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         core_valid_in,
   output logic [127:0] core_in,
   output logic [127:0] core_key,
   output logic         core_decrypt,
   input  logic         core_valid_out,
   input  logic [127:0] core_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         out_last,
   output logic [31:0]  busy_cycles
);

   localparam int unsigned CW = $clog2(OUT_DEPTH + 1);
   localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int unsigned DW = $clog2(CORE_LATENCY + 1);

   localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
   localparam logic [DW-1:0] LAT_C   = DW'(CORE_LATENCY);

   typedef enum logic [1:0] {
      DRAIN    = 2'd0,
      ASSEMBLE = 2'd1,
      FULL     = 2'd2
   } state_t;

   state_t         state_q, state_d;

   // drain timer
   logic [DW-1:0]  drain_cnt;

   // block assembly
   logic [3:0]     byte_cnt;
   logic [127:0]   blk;
   logic           blk_last;
   logic           blk_first;
   logic           msg_open;
   logic [127:0]   key_q;
   logic           dec_q;

   // credits and output buffer
   logic [CW-1:0]  in_flight;
   logic [CW-1:0]  buf_count;
   logic [127:0]   buf_mem [OUT_DEPTH];
   logic [OUT_DEPTH-1:0] tag_mem;
   logic [PW-1:0]  buf_wp;
   logic [PW-1:0]  tag_wp;
   logic [PW-1:0]  rd_ptr;
   logic [3:0]     out_idx;

   // message timer
   logic           busy_run;
   logic [31:0]    busy_q;

   logic           accept;
   logic           issue;
   logic           capture;
   logic           push;
   logic           out_fire;
   logic           pop;
   logic           credit;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // blocks outstanding in the core plus blocks parked in the buffer
   assign credit   = ({1'b0, in_flight} + {1'b0, buf_count}) < {1'b0, DEPTH_C};
   assign accept   = in_valid & in_ready;
   assign issue    = core_valid_in;
   assign capture  = core_valid_out & (state_q != DRAIN);
   assign push     = capture & (buf_count < DEPTH_C);
   assign out_fire = out_valid & out_ready;
   assign pop      = out_fire & (out_idx == 4'd15);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= DRAIN;
      else     state_q <= state_d;
   end

   // next state, input handshake and issue strobe
   always_comb begin
      state_d       = state_q;
      in_ready      = 1'b0;
      core_valid_in = 1'b0;
      unique case (state_q)
         DRAIN: begin
            if (drain_cnt == LAT_C) state_d = ASSEMBLE;
         end
         ASSEMBLE: begin
            in_ready = 1'b1;
            if (in_valid && (in_last || byte_cnt == 4'd15)) state_d = FULL;
         end
         FULL: begin
            if (credit) begin
               core_valid_in = 1'b1;
               state_d       = ASSEMBLE;
            end
         end
         default: state_d = DRAIN;
      endcase
   end

   // drain timer: covers every result that may still be inside the core
   always_ff @(posedge clk) begin
      if (rst || state_q != DRAIN || drain_cnt == LAT_C) drain_cnt <= '0;
      else                                               drain_cnt <= drain_cnt + 1'b1;
   end

   // byte packing (first byte in the MSB) and per-message key/mode latch
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt  <= '0;
         blk       <= '0;
         blk_last  <= 1'b0;
         blk_first <= 1'b0;
         msg_open  <= 1'b0;
         key_q     <= '0;
         dec_q     <= 1'b0;
      end else begin
         if (accept) begin
            if (byte_cnt == 4'd0) begin
               // first byte of a block also clears the padding bytes
               blk       <= {in_data, 120'b0};
               blk_first <= ~msg_open;
               if (!msg_open) begin
                  key_q <= key;
                  dec_q <= decrypt;
               end
            end else begin
               blk[{~byte_cnt, 3'b111} -: 8] <= in_data;
            end
            blk_last <= in_last;
            msg_open <= ~in_last;
            byte_cnt <= byte_cnt + 1'b1;
         end
         if (issue) byte_cnt <= '0;
      end
   end

   // credit counters and buffer pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         in_flight <= '0;
         buf_count <= '0;
         buf_wp    <= '0;
         tag_wp    <= '0;
         rd_ptr    <= '0;
         out_idx   <= '0;
      end else begin
         if (issue && !capture)                         in_flight <= in_flight + 1'b1;
         else if (capture && !issue && in_flight != '0) in_flight <= in_flight - 1'b1;

         if (push && !pop)      buf_count <= buf_count + 1'b1;
         else if (pop && !push) buf_count <= buf_count - 1'b1;

         if (issue) tag_wp <= ptr_next(tag_wp);
         if (push)  buf_wp <= ptr_next(buf_wp);
         if (pop)   rd_ptr <= ptr_next(rd_ptr);

         if (out_fire) out_idx <= out_idx + 1'b1;
      end
   end

   // result and tag storage; results return in issue order, so both share rd_ptr
   always_ff @(posedge clk) begin
      if (push)  buf_mem[buf_wp] <= core_out;
      if (issue) tag_mem[tag_wp] <= blk_last;
   end

   // message timer: first issue to acceptance of the out_last byte
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= '0;
         busy_run <= 1'b0;
      end else if (issue && blk_first) begin
         busy_q   <= 32'd1;
         busy_run <= 1'b1;
      end else if (busy_run) begin
         busy_q <= busy_q + 1'b1;
         if (out_fire && out_last) busy_run <= 1'b0;
      end
   end

   assign out_valid    = (buf_count != '0);
   assign out_data     = out_valid ? buf_mem[rd_ptr][{~out_idx, 3'b111} -: 8] : 8'h00;
   assign out_last     = out_valid & (out_idx == 4'd15) & tag_mem[rd_ptr];
   assign core_in      = blk;
   assign core_key     = key_q;
   assign core_decrypt = dec_q;
   assign busy_cycles  = busy_q;

endmodule

// File: tb/tb_aes_stream_driver.sv
// Bench for aes_stream_driver: directed message table plus hand-written
// back-pressure and mid-run reset sequences, against a fixed-latency core model.
module tb_aes_stream_driver;

   localparam int unsigned OUT_DEPTH = 4;
   localparam int unsigned CL        = 40;

   localparam logic [127:0] C1K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key;
   logic         decrypt;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         core_valid_in;
   logic [127:0] core_in;
   logic [127:0] core_key;
   logic         core_decrypt;
   logic         core_valid_out;
   logic [127:0] core_out;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         out_last;
   logic [31:0]  busy_cycles;

   aes_stream_driver #(.OUT_DEPTH(OUT_DEPTH), .CORE_LATENCY(CL)) dut (
      .clk(clk), .rst(rst), .key(key), .decrypt(decrypt),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .core_valid_in(core_valid_in), .core_in(core_in), .core_key(core_key),
      .core_decrypt(core_decrypt), .core_valid_out(core_valid_out), .core_out(core_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy_cycles(busy_cycles)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // core stand-in: FIPS-197 C.1 pair, otherwise a key xor
   function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k, input logic dec);
      if (k == C1K && !dec && d == C1PT) return C1CT;
      if (k == C1K && dec && d == C1CT)  return C1PT;
      return dec ? (d ^ ~k) : (d ^ k);
   endfunction

   logic [CL-1:0] pv;
   logic [127:0]  pd [CL];
   assign core_valid_out = pv[CL-1];
   assign core_out       = pd[CL-1];

   initial begin
      pv = '0;
      for (int i = 0; i < int'(CL); i++) pd[i] = '0;
      forever begin
         @(posedge clk);
         pv    <= {pv[CL-2:0], core_valid_in};
         pd[0] <= core_fn(core_in, core_key, core_decrypt);
         for (int i = int'(CL) - 1; i > 0; i--) pd[i] <= pd[i-1];
      end
   end

   // observation logs
   logic [7:0]   out_q [$];
   logic         last_q [$];
   int           outcyc_q [$];
   logic [127:0] iss_key [$];
   logic         iss_dec [$];
   int           outstanding = 0;
   int           pop_idx = 0;
   int           max_out = 0;

   always @(negedge clk) begin
      #1;
      if (rst) begin
         outstanding = 0;
         pop_idx     = 0;
      end else begin
         if (core_valid_in) begin
            iss_key.push_back(core_key);
            iss_dec.push_back(core_decrypt);
            outstanding++;
         end
         if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
            outcyc_q.push_back(cyc);
            if (pop_idx == 15) begin
               pop_idx = 0;
               outstanding--;
            end else begin
               pop_idx++;
            end
         end
         if (outstanding > max_out) max_out = outstanding;
      end
   end

   int checks = 0;
   int fails  = 0;
   int t16    = 0;

   task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, " in_ready"},      in_ready, 0);
      check({tag, " core_valid_in"}, core_valid_in, 0);
      check({tag, " out_valid"},     out_valid, 0);
      check({tag, " out_last"},      out_last, 0);
      check({tag, " busy_cycles"},   busy_cycles, 0);
      check({tag, " core_in"},       core_in, 0);
      check({tag, " core_key"},      core_key, 0);
      check({tag, " core_decrypt"},  core_decrypt, 0);
      check({tag, " out_data"},      out_data, 0);
   endtask

   task automatic send_msg(input logic [127:0] k1, input logic [127:0] k2, input logic d1,
                           input logic d2, input int unsigned len, input logic [1023:0] data);
      for (int n = 0; n < int'(len); n++) begin
         int w;
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = data[1023-8*n -: 8];
         in_last  = (n == int'(len) - 1);
         key      = (n == 0) ? k1 : k2;
         decrypt  = (n == 0) ? d1 : d2;
         #1;
         w = 0;
         while (!in_ready && w < 2000) begin
            @(negedge clk);
            #1;
            w++;
         end
         if (w >= 2000) begin
            check("send timeout", w, 0);
            in_valid = 1'b0;
            return;
         end
         if (n == 15) t16 = cyc;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int w = 0;
      while (out_q.size() < n && w < 5000) begin
         @(negedge clk);
         w++;
      end
      check("output timeout", out_q.size() >= n, 1);
   endtask

   typedef struct {
      logic [127:0] k1;
      logic [127:0] k2;
      logic         d1;
      logic         d2;
      int unsigned  len;
      logic [255:0] din;
      logic [255:0] dexp;
      int unsigned  nblk;
      int unsigned  busy;
   } vec_t;

   vec_t vt [4];

   task automatic run_vec(input int i);
      int s_out, s_iss, nb;
      logic [255:0] got;
      logic [31:0]  lm, lexp;
      logic         ok;
      s_out = out_q.size();
      s_iss = iss_key.size();
      nb    = int'(vt[i].nblk) * 16;
      send_msg(vt[i].k1, vt[i].k2, vt[i].d1, vt[i].d2, vt[i].len, {vt[i].din, 768'b0});
      wait_out(s_out + nb);
      got  = '0;
      lm   = '0;
      lexp = '0;
      lexp[nb-1] = 1'b1;
      for (int j = 0; j < nb; j++) begin
         got[255-8*j -: 8] = out_q[s_out+j];
         lm[j]             = last_q[s_out+j];
      end
      check($sformatf("v%0d data", i), got, vt[i].dexp);
      check($sformatf("v%0d out_last", i), lm, lexp);
      check($sformatf("v%0d issues", i), iss_key.size() - s_iss, vt[i].nblk);
      ok = 1'b1;
      for (int j = 0; j < int'(vt[i].nblk); j++)
         if (iss_key[s_iss+j] !== vt[i].k1 || iss_dec[s_iss+j] !== vt[i].d1) ok = 1'b0;
      check($sformatf("v%0d key/mode held", i), ok, 1);
      check($sformatf("v%0d first-out latency", i), outcyc_q[s_out] - t16, CL + 2);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d busy_cycles", i), busy_cycles, vt[i].busy);
   endtask

   initial begin
      int n, s_out, s_iss, w;
      logic seen;
      logic [1023:0] d4, g4, lm4, le4;

      vt[0] = '{k1: C1K, k2: C1K, d1: 1'b0, d2: 1'b0, len: 16,
                din: {C1PT, 128'h0}, dexp: {C1CT, 128'h0}, nblk: 1, busy: CL + 17};
      vt[1] = '{k1: C1K, k2: C1K, d1: 1'b1, d2: 1'b1, len: 16,
                din: {C1CT, 128'h0}, dexp: {C1PT, 128'h0}, nblk: 1, busy: CL + 17};
      vt[2] = '{k1: 128'h0, k2: 128'h0, d1: 1'b0, d2: 1'b0, len: 20,
                din:  {160'h101112131415161718191a1b1c1d1e1f20212223, 96'h0},
                dexp: {160'h101112131415161718191a1b1c1d1e1f20212223, 96'h0},
                nblk: 2, busy: CL + 33};
      vt[3] = '{k1: 128'h0, k2: 128'hdeadbeef_01234567_89abcdef_55aa55aa, d1: 1'b0, d2: 1'b1, len: 24,
                din:  {192'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7, 64'h0},
                dexp: {192'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7, 64'h0},
                nblk: 2, busy: CL + 33};

      rst = 1'b1; key = '0; decrypt = 1'b0; in_valid = 1'b0; in_data = '0;
      in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("reset");
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!in_ready && n < int'(CL) + 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("in_ready rise after reset", n, CL + 1);

      for (int i = 0; i < 4; i++) run_vec(i);

      // back-pressure: 8 blocks, consumer stalled
      for (int i = 0; i < 128; i++) d4[1023-8*i -: 8] = 8'(i);
      s_out = out_q.size();
      s_iss = iss_key.size();
      @(negedge clk);
      out_ready = 1'b0;
      fork
         send_msg(128'h0, 128'h0, 1'b0, 1'b0, 128, d4);
         begin
            repeat (300) @(negedge clk);
            #1;
            check("stall issues", iss_key.size() - s_iss, OUT_DEPTH);
            check("stall in_ready", in_ready, 0);
            check("stall out_valid", out_valid, 1);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      wait_out(s_out + 128);
      g4 = '0; lm4 = '0; le4 = '0;
      le4[127] = 1'b1;
      for (int j = 0; j < 128; j++) begin
         g4[1023-8*j -: 8] = out_q[s_out+j];
         lm4[j]            = last_q[s_out+j];
      end
      check("stall data order", g4, d4);
      check("stall out_last", lm4, le4);
      check("stall total issues", iss_key.size() - s_iss, 8);
      check("max outstanding", max_out <= int'(OUT_DEPTH), 1);

      // reset 10 cycles after the third issue, with results still in the core
      s_iss = iss_key.size();
      @(negedge clk);
      out_ready = 1'b0;
      send_msg(128'h0, 128'h0, 1'b0, 1'b0, 48, {384'h0102030405060708090a0b0c0d0e0f10_1112131415161718191a1b1c1d1e1f20_2122232425262728292a2b2c2d2e2f30, 640'h0});
      w = 0;
      while (iss_key.size() < s_iss + 3 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check("three issues before reset", iss_key.size() - s_iss, 3);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      reset_checks("mid reset");
      s_out = out_q.size();
      seen = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (!in_ready && n < int'(CL) + 20) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
         n++;
      end
      check("in_ready rise after mid reset", n, CL + 1);
      repeat (100) begin
         @(negedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("no stale out_valid", seen, 0);
      check("no stale output bytes", out_q.size() - s_out, 0);

      run_vec(0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
